seg_scan_receiver: RTL

Receiving end of the multiplexed seven-segment scan interface. It watches the time-multiplexed segment and position bus driven by the display scanner (`seg_display` / `seg_position`), captures each digit's segment pattern once it has settled, and decodes it back to a hex nibble. When every position has been seen, it publishes the whole frame. It is used as the on-chip/bench monitor that closes the loop on the display output path, so displayed player values can be checked against the values that were sent.

---
 rtl/seg_scan_receiver.sv | 104 ++++++++++
 1 files changed

// File: rtl/seg_scan_receiver.sv
// seg_scan_receiver: watches a multiplexed seven-segment scan bus, captures each settled digit,
// and publishes decoded frames once all eight positions have been seen.
module seg_scan_receiver #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_display,
    input  logic [7:0]  seg_position,
    output logic [55:0] digit_code,
    output logic [31:0] digit_value,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        err_multi
);
    typedef enum logic [1:0] {WAIT, SETTLING, HOLD} state_t;
    state_t state;
    logic [7:0] pos_r, pos_q, seen, seen_n;
    logic [6:0] seg_r;
    logic [3:0] cnt;
    logic [7:0][6:0] slot, slot_n;
    logic one_hot, multi, changed, capture;
    logic [2:0] idx;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = 5'h10;
            7'b0110000: decode = 5'h11;
            7'b1101101: decode = 5'h12;
            7'b1111001: decode = 5'h13;
            7'b0110011: decode = 5'h14;
            7'b1011011: decode = 5'h15;
            7'b1011111: decode = 5'h16;
            7'b1110000: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1111011: decode = 5'h19;
            7'b1110111: decode = 5'h1A;
            7'b0011111: decode = 5'h1B;
            7'b1001110: decode = 5'h1C;
            7'b0111101: decode = 5'h1D;
            7'b1001111: decode = 5'h1E;
            7'b1000111: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        multi = (pos_r & (pos_r - 8'd1)) != 8'd0;
        one_hot = pos_r != 8'd0 && !multi;
        changed = pos_r != pos_q;
        // the counter has already reached SETTLE and the position is still stable
        capture = state == SETTLING && !changed && cnt == 4'(SETTLE);
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (pos_r[i]) idx = 3'(i);
        seen_n = seen | pos_r;
        slot_n = slot;
        slot_n[idx] = seg_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT;
            cnt <= 4'd0;
            pos_r <= 8'd0;
            pos_q <= 8'd0;
            seg_r <= 7'd0;
            seen <= 8'd0;
            slot <= '0;
            digit_code <= 56'd0;
            digit_value <= 32'd0;
            digit_valid <= 8'd0;
            frame_done <= 1'b0;
            frame_count <= 8'd0;
            err_multi <= 1'b0;
        end else begin
            pos_r <= seg_position;
            seg_r <= seg_display;
            pos_q <= pos_r;
            err_multi <= multi;
            frame_done <= 1'b0;
            if (changed) begin
                state <= one_hot ? SETTLING : WAIT;
                cnt <= one_hot ? 4'd1 : 4'd0;
            end else if (capture) begin
                state <= HOLD;
                slot <= slot_n;
                if (seen_n == 8'hFF) begin
                    seen <= 8'd0;
                    frame_done <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                    digit_code <= slot_n;
                    for (int i = 0; i < 8; i++)
                        {digit_valid[i], digit_value[4*i +: 4]} <= decode(slot_n[i]);
                end else begin
                    seen <= seen_n;
                end
            end else if (state == SETTLING) begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule
